// File: rtl/mem_bus_pkg.sv
// Shared widths, state encoding and request record for the MemoryBus arbiter.
// The port index travels in ID bits [5:4]; the requester tag sits in [3:0].
package mem_bus_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 24;
    localparam int ID_W    = 8;
    localparam int TAG_LO  = 4;
    localparam int PORT_LO = 4;
    localparam int PORT_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
    } bus_req_t;

    function automatic logic [ID_W-1:0] make_ms_id(input logic [PORT_W-1:0] port,
                                                   input logic [ID_W-1:0]   id);
        return {{(ID_W-PORT_LO-PORT_W){1'b0}}, port, id[TAG_LO-1:0]};
    endfunction

endpackage

// File: rtl/bus_resp_slot.sv
// One-entry response buffer for {data, id}. A new entry may be accepted in the
// same cycle the current one is taken, so back-to-back responses see no bubble.
module bus_resp_slot
    import mem_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              en_i,
    input  logic              in_valid_i,
    input  logic              in_keep_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ID_W-1:0]   in_id_i,
    output logic              in_taken_o,
    input  logic              out_take_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ID_W-1:0]   id_o
);

    logic              full_q;
    logic [DATA_W-1:0] data_q;
    logic [ID_W-1:0]   id_q;

    assign in_taken_o = en_i && (!full_q || out_take_i);

    // Accepted but not kept (in_keep_i low) means the response is dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            full_q <= 1'b0;
            data_q <= '0;
            id_q   <= '0;
        end else if (in_valid_i && in_taken_o && in_keep_i) begin
            full_q <= 1'b1;
            data_q <= in_data_i;
            id_q   <= in_id_i;
        end else if (out_take_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign id_o   = id_q;

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin share of one MemoryBus master port among NUM_PORTS requesters,
// with tag-routed read responses returned through a one-entry slot.
//
//   state | meaning
//   IDLE  | no grant held; picks next valid requester after last
//   BUSY  | grant held; request driven downstream until msTaken
module memory_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NUM_PORTS-1:0]               req_valid,
    input  logic [NUM_PORTS-1:0]               req_write,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]   req_address,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]   req_data,
    input  logic [NUM_PORTS-1:0][ID_W-1:0]     req_id,
    output logic [NUM_PORTS-1:0]               req_taken,
    output logic [NUM_PORTS-1:0]               rsp_valid,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]   rsp_data,
    output logic [NUM_PORTS-1:0][ID_W-1:0]     rsp_id,
    input  logic [NUM_PORTS-1:0]               rsp_taken,
    output logic                               msValid,
    output logic                               msWrite,
    output logic [ADDR_W-1:0]                  msAddress,
    output logic [DATA_W-1:0]                  msData,
    output logic [ID_W-1:0]                    msID,
    input  logic                               msTaken,
    input  logic                               smValid,
    input  logic [DATA_W-1:0]                  smData,
    input  logic [ID_W-1:0]                    smID,
    output logic                               smTaken,
    output logic                               bad_id
);

    arb_state_t        state_q;
    logic [PORT_W-1:0] grant_q;
    logic [PORT_W-1:0] last_q;
    logic              ready_q;
    logic              bad_id_q;

    function automatic logic [PORT_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] v,
                                                  input logic [PORT_W-1:0]    last);
        logic [PORT_W-1:0] r;
        logic              found;
        int                j;
        r     = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            j = (int'(last) + i) % NUM_PORTS;
            if (!found && v[j]) begin
                r     = PORT_W'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= PORT_W'(NUM_PORTS - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q <= rr_pick(req_valid, last_q);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (msTaken) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    bus_req_t sel_req;
    logic     sel_valid;

    always_comb begin
        sel_req   = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant_q == PORT_W'(k)) begin
                sel_valid       = req_valid[k];
                sel_req.write   = req_write[k];
                sel_req.address = req_address[k];
                sel_req.data    = req_data[k];
                sel_req.id      = req_id[k];
            end
        end
    end

    always_comb begin
        msValid   = 1'b0;
        msWrite   = 1'b0;
        msAddress = '0;
        msData    = '0;
        msID      = '0;
        req_taken = '0;
        if (state_q == BUSY) begin
            msValid   = sel_valid;
            msWrite   = sel_req.write;
            msAddress = sel_req.address;
            msData    = sel_req.data;
            msID      = make_ms_id(grant_q, sel_req.id);
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (grant_q == PORT_W'(k)) req_taken[k] = msTaken;
            end
        end
    end

    // Holds smTaken low through reset and the first cycle after it.
    always_ff @(posedge clk) begin
        if (!rstn) ready_q <= 1'b0;
        else       ready_q <= 1'b1;
    end

    logic [DATA_W-1:0] slot_data;
    logic [ID_W-1:0]   slot_id;
    logic              slot_full;
    logic              slot_take;
    logic [PORT_W-1:0] slot_idx;
    logic [PORT_W-1:0] in_idx;
    logic              in_keep;

    assign slot_idx = slot_id[PORT_LO+PORT_W-1:PORT_LO];
    assign in_idx   = smID[PORT_LO+PORT_W-1:PORT_LO];
    assign in_keep  = (int'(in_idx) < NUM_PORTS);

    always_comb begin
        slot_take = 1'b0;
        rsp_valid = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            rsp_data[k] = slot_data;
            rsp_id[k]   = {{(ID_W-TAG_LO){1'b0}}, slot_id[TAG_LO-1:0]};
            if (slot_full && slot_idx == PORT_W'(k)) begin
                rsp_valid[k] = 1'b1;
                slot_take    = rsp_taken[k];
            end
        end
    end

    bus_resp_slot u_slot (
        .clk        (clk),
        .rstn       (rstn),
        .en_i       (ready_q),
        .in_valid_i (smValid),
        .in_keep_i  (in_keep),
        .in_data_i  (smData),
        .in_id_i    (smID),
        .in_taken_o (smTaken),
        .out_take_i (slot_take),
        .full_o     (slot_full),
        .data_o     (slot_data),
        .id_o       (slot_id)
    );

    always_ff @(posedge clk) begin
        if (!rstn)                               bad_id_q <= 1'b0;
        else if (smValid && smTaken && !in_keep) bad_id_q <= 1'b1;
    end

    assign bad_id = bad_id_q;

    logic unused_bits;
    assign unused_bits = ^{sel_req.id[ID_W-1:TAG_LO], slot_id[ID_W-1:PORT_LO+PORT_W]};

endmodule
